// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// A grant lasts up to BURST words, or until its producer drops valid; full blocks writes combinationally.
module fifo_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int BURST  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        full,
    output logic                        w_en,
    output logic [DATA_W-1:0]           data_in,
    output logic [$clog2(N_REQ)-1:0]    gnt_id,
    output logic                        busy
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   gnt_id_reg, gnt_id_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [3:0]        burst_cnt_reg, burst_cnt_next;

    logic [DATA_W-1:0] req_word [N_REQ];
    logic [ID_W-1:0]   rr_sel;
    logic              rr_found;
    logic [ID_W:0]     rr_cand;
    logic [ID_W-1:0]   gnt_succ;
    logic              granted_valid;
    logic              xfer;
    logic              last_word;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_word[gi]  = req_data[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = (state_reg == GRANT) && (gnt_id_reg == ID_W'(gi)) && !full;
        end
    endgenerate

    // No register between full and w_en, so a full FIFO can never be written.
    assign granted_valid = req_valid[gnt_id_reg];
    assign xfer          = (state_reg == GRANT) && granted_valid && !full;
    assign w_en          = xfer;
    assign data_in       = xfer ? req_word[gnt_id_reg] : '0;
    assign last_word     = (burst_cnt_reg == 4'(BURST - 1));
    assign gnt_succ      = (gnt_id_reg == ID_W'(N_REQ - 1)) ? '0 : gnt_id_reg + ID_W'(1);
    assign gnt_id        = gnt_id_reg;
    assign busy          = (state_reg == GRANT);

    // Scan from the highest offset down so the nearest requester at or after rr_ptr wins.
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        rr_cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            rr_cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (rr_cand >= (ID_W+1)'(N_REQ)) begin
                rr_cand = rr_cand - (ID_W+1)'(N_REQ);
            end
            if (req_valid[rr_cand[ID_W-1:0]]) begin
                rr_sel   = rr_cand[ID_W-1:0];
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        gnt_id_next    = gnt_id_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    state_next     = GRANT;
                    gnt_id_next    = rr_sel;
                    burst_cnt_next = '0;
                end
            end
            GRANT: begin
                // A drained producer releases even while the FIFO is full.
                if (!granted_valid) begin
                    state_next  = IDLE;
                    rr_ptr_next = gnt_succ;
                end else if (xfer) begin
                    burst_cnt_next = burst_cnt_reg + 4'd1;
                    if (last_word) begin
                        state_next  = IDLE;
                        rr_ptr_next = gnt_succ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_id_reg    <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_id_reg    <= gnt_id_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producers feed word queues; a grant/word-count model predicts
// every cycle's FIFO write, ready vector, grant owner and busy flag.
module tb_fifo_wr_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 16;
    localparam int BURST  = 4;
    localparam int ID_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        req_ready;
    logic                    full = 1'b0;
    logic                    w_en;
    logic [DATA_W-1:0]       data_in;
    logic [ID_W-1:0]         gnt_id;
    logic                    busy;

    fifo_wr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .w_en      (w_en),
        .data_in   (data_in),
        .gnt_id    (gnt_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Producer side: pending word per producer, held until accepted
    logic [DATA_W-1:0] pq [N_REQ][$];
    bit                pend [N_REQ];
    int                gap_pct  = 0;
    int                full_pct = 0;

    // Model: who owns the port, words taken this grant, where the next search starts
    bit m_busy  = 0;
    int m_owner = 0;
    int m_count = 0;
    int m_next  = 0;

    // Observations of the DUT per phase
    int tick_idx, dut_writes, first_wr_tick, last_wr_tick;
    int grant_log[$];
    int grant_tick[$];
    bit prev_busy;

    function automatic bit work_left();
        for (int i = 0; i < N_REQ; i++) if (pq[i].size() > 0) return 1'b1;
        return m_busy;
    endfunction

    function automatic bit rand_full();
        return ($urandom_range(99) < 32'(full_pct));
    endfunction

    task automatic start_phase();
        tick_idx      = 0;
        dut_writes    = 0;
        first_wr_tick = -1;
        last_wr_tick  = -1;
        grant_log.delete();
        grant_tick.delete();
    endtask

    task automatic tick(input bit f);
        logic [N_REQ-1:0]  exp_ready;
        logic [DATA_W-1:0] exp_data;
        bit                exp_wen;
        int                c;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pend[i] && pq[i].size() > 0 && $urandom_range(99) >= 32'(gap_pct)) pend[i] = 1'b1;
            req_valid[i] = pend[i];
            req_data[i*DATA_W +: DATA_W] = pend[i] ? pq[i][0] : DATA_W'($urandom);
        end
        full = f;
        @(negedge clk);
        exp_ready = '0;
        exp_wen   = 1'b0;
        exp_data  = '0;
        if (m_busy && !full) begin
            exp_ready[m_owner] = 1'b1;
            if (req_valid[m_owner]) begin
                exp_wen  = 1'b1;
                exp_data = pq[m_owner][0];
            end
        end
        check_eq("w_en", 32'(w_en), 32'(exp_wen));
        check_eq("data_in", 32'(data_in), 32'(exp_data));
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("gnt_id", 32'(gnt_id), 32'(m_owner));
        if (!w_en) check_eq("data_hygiene", 32'(data_in), 32'd0);
        check_eq("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (w_en) begin
            dut_writes++;
            if (first_wr_tick < 0) first_wr_tick = tick_idx;
            last_wr_tick = tick_idx;
            $display("write tick=%0d gnt=%0d data=%04h", tick_idx, gnt_id, data_in);
        end
        if (busy && !prev_busy) begin
            grant_log.push_back(int'(gnt_id));
            grant_tick.push_back(tick_idx);
        end
        prev_busy = busy;
        // Model update for the coming edge
        if (exp_wen) begin
            void'(pq[m_owner].pop_front());
            pend[m_owner] = 1'b0;
            m_count++;
        end
        if (!m_busy) begin
            for (int k = 0; k < N_REQ; k++) begin
                c = (m_next + k) % N_REQ;
                if (req_valid[c]) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_count = 0;
                    break;
                end
            end
        end else if (!req_valid[m_owner] || (exp_wen && m_count == BURST)) begin
            m_busy = 1'b0;
            m_next = (m_owner + 1) % N_REQ;
        end
        tick_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        while (work_left() && guard < 3000) begin
            tick(rand_full());
            guard++;
        end
        check_eq("drain_done", 32'(work_left()), 32'd0);
    endtask

    // Asynchronous reset pulse away from clock edges; outputs must clear at once
    task automatic rst_seq();
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_w_en", 32'(w_en), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_data_in", 32'(data_in), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_gnt_id", 32'(gnt_id), 32'd0);
        for (int i = 0; i < N_REQ; i++) begin
            pq[i].delete();
            pend[i] = 1'b0;
        end
        req_valid = '0;
        full      = 1'b0;
        m_busy    = 1'b0;
        m_owner   = 0;
        m_count   = 0;
        m_next    = 0;
        prev_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int stall_left;
        int g;
        bit f;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_seq();

        // Reset mid-burst with all producers valid, then arbitration latency
        start_phase();
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < 8; j++) pq[i].push_back(DATA_W'(16'h1000 * (i + 1) + j));
        repeat (3) tick(1'b0);
        rst_seq();
        start_phase();
        for (int j = 0; j < 4; j++) pq[0].push_back(DATA_W'(16'h5000 + j));
        drain();
        check_eq("first_write_latency", 32'(first_wr_tick), 32'd1);
        check_eq("latency_writes", 32'(dut_writes), 32'd4);

        // Single producer: 4-word burst, one idle cycle, remaining 2 words
        start_phase();
        for (int j = 0; j < 6; j++) pq[2].push_back(DATA_W'(16'hA000 + j));
        drain();
        check_eq("single_writes", 32'(dut_writes), 32'd6);
        check_eq("single_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check_eq("single_gnt0", 32'(grant_log[0]), 32'd2);
            check_eq("single_gnt1", 32'(grant_log[1]), 32'd2);
            check_eq("single_spacing", 32'(grant_tick[1] - grant_tick[0]), 32'(BURST + 1));
        end

        // Round-robin rotation with every producer streaming
        rst_seq();
        start_phase();
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < 8; j++) pq[i].push_back(DATA_W'(16'h2000 * (i + 1) + j));
        drain();
        check_eq("rr_writes", 32'(dut_writes), 32'd32);
        check_eq("rr_grants", 32'(grant_log.size()), 32'd8);
        if (grant_log.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check_eq("rr_order", 32'(grant_log[k]), 32'(k % N_REQ));
                if (k > 0) check_eq("rr_spacing", 32'(grant_tick[k] - grant_tick[k-1]), 32'(BURST + 1));
            end
        end

        // Full stall for 3 cycles after producer 1's second word
        rst_seq();
        start_phase();
        for (int j = 0; j < 4; j++) pq[1].push_back(DATA_W'(16'hB100 + j));
        stall_left = 3;
        g = 0;
        while (work_left() && g < 100) begin
            f = m_busy && (m_count == 2) && (stall_left > 0);
            if (f) stall_left--;
            tick(f);
            g++;
        end
        check_eq("stall_done", 32'(work_left()), 32'd0);
        check_eq("stall_writes", 32'(dut_writes), 32'd4);
        check_eq("stall_grants", 32'(grant_log.size()), 32'd1);
        check_eq("stall_last_write", 32'(last_wr_tick), 32'd7);

        // Early drain: producer 3 sends one word; producer 0 wins the next arbitration
        rst_seq();
        start_phase();
        pq[3].push_back(16'hC300);
        tick(1'b0);
        tick(1'b0);
        for (int j = 0; j < 4; j++) pq[0].push_back(DATA_W'(16'hC000 + j));
        tick(1'b0);
        for (int j = 1; j < 5; j++) pq[3].push_back(DATA_W'(16'hC300 + j));
        drain();
        check_eq("drain_writes", 32'(dut_writes), 32'd9);
        check_eq("drain_grants", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            check_eq("drain_gnt0", 32'(grant_log[0]), 32'd3);
            check_eq("drain_gnt1", 32'(grant_log[1]), 32'd0);
            check_eq("drain_gnt2", 32'(grant_log[2]), 32'd3);
        end

        // Random traffic with valid gaps and FIFO backpressure
        rst_seq();
        gap_pct  = 30;
        full_pct = 25;
        for (int r = 0; r < 3; r++) begin
            start_phase();
            for (int i = 0; i < N_REQ; i++) begin
                int len = int'($urandom_range(12));
                for (int j = 0; j < len; j++) pq[i].push_back(DATA_W'($urandom));
            end
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single 16-bit FIFO write port (w_en/data_in/full) between N_REQ producers. Each producer offers words on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, forwards its words into the FIFO, and never writes while full is asserted. It sits directly in front of the FIFO write side; the FIFO read side is untouched.

## Interface
Parameters:
- N_REQ, 4, number of producers (2..8)
- DATA_W, 16, word width; must match the FIFO data_in width
- BURST, 4, maximum words accepted per grant (1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous assertion, active-low
- req_valid  in  N_REQ  producer i has a word on its data slice
- req_data  in  N_REQ*DATA_W  producer i word at bits [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  word of producer i is accepted this cycle when valid&ready
- full  in  1  FIFO full flag
- w_en  out  1  FIFO write enable
- data_in  out  DATA_W  FIFO write data
- gnt_id  out  clog2(N_REQ)  index of the currently granted producer (registered)
- busy  out  1  high while in GRANT (registered)

## Operation
- Two states: IDLE, GRANT. Registered state: state, gnt_id, rr_ptr (clog2(N_REQ) bits), burst_cnt (4 bits).
- IDLE:
  - No output activity: req_ready=0, w_en=0.
  - If any req_valid is high, select the first set bit searching rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Load gnt_id with that index, clear burst_cnt, and go to GRANT.
- GRANT:
  - req_ready[gnt_id] = ~full; all other req_ready bits = 0.
  - w_en = req_valid[gnt_id] & ~full.
  - data_in = req_data slice gnt_id when w_en=1, else all zeros. data_in is 0 whenever w_en=0.
  - On each transfer (w_en=1), burst_cnt increments.
- Release from GRANT to IDLE, with rr_ptr = (gnt_id+1) mod N_REQ, when either:
  - a transfer occurs with burst_cnt==BURST-1 (the last word of the burst is still written), or
  - req_valid[gnt_id]==0 in a GRANT cycle (the producer drained; no transfer that cycle).
- Full stall:
  - While full=1 in GRANT, there is no transfer and burst_cnt holds.
  - The grant is held indefinitely; there is no timeout.
  - A producer dropping valid during the stall still releases.
- Fairness: the producer just released has the lowest priority at the next arbitration.
- A requester must hold valid and data stable until it sees ready; the arbiter does not check this.
- Reset (rst_n=0, any time including mid-burst):
  - state=IDLE, gnt_id=0, rr_ptr=0, burst_cnt=0.
  - Hence busy=0, w_en=0, req_ready=0, data_in=0.
  - A word in flight is dropped; no FIFO write occurs during or in the first cycle after reset.

## Timing
- w_en, data_in and req_ready are combinational from state, gnt_id, req_valid, req_data and full. There is no register between full and w_en, so the FIFO cannot be overwritten.
- gnt_id and busy are registered outputs.
- Arbitration latency is one cycle: valid rises in IDLE cycle t, the grant is loaded at the posedge ending t, and the first write is in cycle t+1.
- Throughput:
  - A BURST-word grant with continuous valid and full=0 takes BURST+1 cycles, including one IDLE arbitration cycle.
  - Back-to-back grants to different producers have exactly one idle cycle between them.
- The release decision and the next rr_ptr take effect at the same posedge as the last transfer.

## Test plan
- **Reset values.** Assert rst_n=0 mid-burst with req_valid=4'hF. Required: w_en, req_ready and data_in drop to 0 immediately; busy=0 and gnt_id=0 after reset. With rst_n=1 and req_valid=4'b0001, the first w_en appears 2 cycles after release (1 IDLE cycle, then GRANT).
- **Single producer burst.** Producer 2 holds valid with data 16'hA000..A005, full=0. Required:
  - 4 writes A000..A003, then 1 idle cycle, then A004, A005.
  - Release on valid drop, busy=0 in the following cycle.
- **Round-robin rotation.** req_valid=4'hF held, each producer streaming. Required:
  - gnt_id sequence is 0,1,2,3,0 with 4 writes per grant.
  - Exactly 1 idle cycle between grants.
- **Full stall.** Producer 1 granted; full=1 for 3 cycles after its 2nd word. Required:
  - w_en=0 and req_ready=0 during the stall, grant held.
  - Then the remaining 2 words are written, then release; total writes = 4.
- **Early drain.** Producer 3 sends 1 word then drops valid. Required:
  - 1 write, release in the next cycle, rr_ptr=0.
  - Producer 0 (valid) is granted next, ahead of producer 3.
- **Data hygiene.** Across all cases, check data_in==0 whenever w_en==0, and req_ready is one-hot or zero every cycle.
